// File: rtl/reflet_int_source_pkg.sv
// Shared register-offset definitions and routing helpers for the interrupt source block.
package reflet_int_source_pkg;

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_MAP     = 3'd2,
    REG_MODE    = 3'd3,
    REG_RAW     = 3'd4
  } reg_sel_e;

  localparam int NUM_REGS = 5;

  // Default routing spreads sources round-robin across the four CPU lines.
  function automatic logic [1:0] default_line(input int src_idx);
    return 2'(src_idx % 4);
  endfunction

endpackage

// File: rtl/reflet_sync_edge.sv
// One-bit 2-flop synchronizer with a history flop; reports synchronized level and rising edge.
module reflet_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (enable) begin
      s1_d = din;
      s2_d = s1_q;
      s3_d = s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/reflet_int_source.sv
// Interrupt source block: synchronizes peripheral events, latches them as pending and
// routes enabled pending sources onto the CPU's four ext_int lines through a programmable map.
module reflet_int_source
  import reflet_int_source_pkg::*;
#(
  parameter int                    wordsize  = 16,
  parameter logic [wordsize-1:0]   base_addr = 16'hFF00,
  parameter int                    nsources  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [nsources-1:0] src,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic [3:0]          ext_int
);

  function automatic logic [2*nsources-1:0] map_default();
    logic [2*nsources-1:0] m;
    m = '0;
    for (int i = 0; i < nsources; i++) m[2*i +: 2] = default_line(i);
    return m;
  endfunction

  localparam logic [2*nsources-1:0] MAP_RST = map_default();

  logic [nsources-1:0]   level, rise, set_ev, clr;
  logic [nsources-1:0]   pend_q, pend_d, en_q, en_d, mode_q, mode_d;
  logic [2*nsources-1:0] map_q, map_d;
  logic [3:0]            ext_q, ext_d;
  logic [wordsize-1:0]   offset;
  logic                  in_range, wr;

  for (genvar g = 0; g < nsources; g++) begin : g_sync
    reflet_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .din    (src[g]),
      .level  (level[g]),
      .rise   (rise[g])
    );
  end

  assign offset   = addr - base_addr;
  assign in_range = (addr >= base_addr) && (offset < wordsize'(NUM_REGS));
  assign wr       = write_en & in_range & enable;
  assign set_ev   = (mode_q & level) | (~mode_q & rise);

  always_comb begin
    en_d   = en_q;
    map_d  = map_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr) begin
      case (offset[2:0])
        REG_PENDING: clr    = data_in[nsources-1:0];
        REG_ENABLE:  en_d   = data_in[nsources-1:0];
        REG_MAP:     map_d  = data_in[2*nsources-1:0];
        REG_MODE:    mode_d = data_in[nsources-1:0];
        default:     ;
      endcase
    end
    // A new event wins over a simultaneous software clear.
    pend_d = enable ? ((pend_q & ~clr) | set_ev) : pend_q;
  end

  always_comb begin
    ext_d = ext_q;
    if (enable) begin
      ext_d = '0;
      for (int i = 0; i < nsources; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (map_q[2*i +: 2] == 2'(k)) ext_d[k] = ext_d[k] | (pend_q[i] & en_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      en_q   <= '0;
      map_q  <= MAP_RST;
      mode_q <= '0;
      ext_q  <= '0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      map_q  <= map_d;
      mode_q <= mode_d;
      ext_q  <= ext_d;
    end
  end

  // Off-range addresses read 0 so several peripherals' buses can be ORed.
  always_comb begin
    data_out = '0;
    if (in_range) begin
      case (offset[2:0])
        REG_PENDING: data_out[nsources-1:0]   = pend_q;
        REG_ENABLE:  data_out[nsources-1:0]   = en_q;
        REG_MAP:     data_out[2*nsources-1:0] = map_q;
        REG_MODE:    data_out[nsources-1:0]   = mode_q;
        REG_RAW:     data_out[nsources-1:0]   = level;
        default:     data_out = '0;
      endcase
    end
  end

  assign ext_int = ext_q;

endmodule

// File: tb/tb_reflet_int_source.sv
// Randomized bench for reflet_int_source against a sample-history reference model.
module tb_reflet_int_source;

  localparam int          NS   = 8;
  localparam logic [15:0] BASE = 16'hFF00;

  logic          clk = 1'b0;
  logic          reset, enable, write_en;
  logic [NS-1:0] src;
  logic [15:0]   addr, data_in, data_out;
  logic [3:0]    ext_int;

  reflet_int_source #(.wordsize(16), .base_addr(BASE), .nsources(NS)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .src      (src),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .ext_int  (ext_int)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: samp[0] is the most recent src sample, samp[1] the one before, etc.
  logic [NS-1:0] m_pend, m_en, m_mode;
  logic [15:0]   m_map;
  logic [3:0]    m_ext;
  logic [NS-1:0] samp[$];

  function automatic void m_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_ext = '0;
    m_map  = 16'hE4E4;
    samp   = '{8'h00, 8'h00, 8'h00};
  endfunction

  function automatic bit m_hit(input logic [15:0] a);
    return (a >= BASE) && (a - BASE < 16'd5);
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (!m_hit(a)) return 16'h0;
    case (a - BASE)
      16'd0:   return {8'h00, m_pend};
      16'd1:   return {8'h00, m_en};
      16'd2:   return m_map;
      16'd3:   return {8'h00, m_mode};
      default: return {8'h00, samp[1]};
    endcase
  endfunction

  function automatic void m_step();
    logic [3:0]    e;
    logic [NS-1:0] set_v, clr_v, lv, prev;
    if (!enable) return;
    e = '0;
    for (int i = 0; i < NS; i++) if (m_pend[i] && m_en[i]) e[m_map[2*i +: 2]] = 1'b1;
    lv    = samp[1];
    prev  = samp[2];
    set_v = (m_mode & lv) | (~m_mode & lv & ~prev);
    clr_v = '0;
    if (write_en && m_hit(addr)) begin
      case (addr - BASE)
        16'd0:   clr_v  = data_in[7:0];
        16'd1:   m_en   = data_in[7:0];
        16'd2:   m_map  = data_in;
        16'd3:   m_mode = data_in[7:0];
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr_v) | set_v;
    m_ext  = e;
    samp.push_front(src);
    void'(samp.pop_back());
  endfunction

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    chk("ext", {12'h0, ext_int}, {12'h0, m_ext});
    chk("rd", data_out, m_read(addr));
  endtask

  logic [15:0] rst_vals [5];

  initial begin
    rst_vals = '{16'h0000, 16'h0000, 16'hE4E4, 16'h0000, 16'h0000};
    reset = 1'b0; enable = 1'b1; src = '0; addr = BASE; data_in = '0; write_en = 1'b0;
    m_reset();
    #12;
    for (int i = 0; i < 5; i++) begin
      addr = BASE + 16'(i);
      #1 chk($sformatf("rst_reg%0d", i), data_out, rst_vals[i]);
    end
    chk("rst_ext", {12'h0, ext_int}, 16'h0);
    @(negedge clk) reset = 1'b1;

    // Edge event on source 0: pending two edges after first sampling, ext_int one later.
    addr = BASE + 16'd1; data_in = 16'h0001; write_en = 1'b1;
    cycle();
    write_en = 1'b0; addr = BASE; src[0] = 1'b1;
    cycle(); chk("lat_e0", data_out, 16'h0000);
    cycle(); chk("lat_e1", data_out, 16'h0000);
    cycle(); chk("lat_e2", data_out, 16'h0001); chk("lat_e2_ext", {12'h0, ext_int}, 16'h0);
    src[0] = 1'b0;
    cycle(); chk("lat_e3_ext", {12'h0, ext_int}, 16'h0001);
    data_in = 16'h0001; write_en = 1'b1;
    cycle(); chk("clr_pend", data_out, 16'h0000);
    write_en = 1'b0;
    cycle(); chk("clr_ext", {12'h0, ext_int}, 16'h0);
    addr = BASE + 16'd5; #1 chk("off_hi", data_out, 16'h0000);
    addr = BASE - 16'd1; #1 chk("off_lo", data_out, 16'h0000);

    for (int n = 0; n < 2000; n++) begin
      int r;
      enable   = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 5) == 0) src[b] = ~src[b];
      write_en = ($urandom_range(0, 3) == 0);
      data_in  = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       addr = BASE + 16'(r % 5);
      else if (r == 7) addr = BASE + 16'd5;
      else if (r == 8) addr = BASE - 16'd1;
      else             addr = 16'($urandom);
      cycle();
      if (n == 1000) begin
        #2 reset = 1'b0;
        #1 chk("arst_ext", {12'h0, ext_int}, 16'h0);
        m_reset();
        chk("arst_rd", data_out, m_read(addr));
        @(negedge clk) reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
